stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the D/E/M forwarding muxes. It decides when an instruction in D cannot be satisfied by forwarding and must wait: PC and IF/ID freeze, and a bubble is inserted into ID/EX. It also owns the multiply/divide busy sequencer, which blocks HI/LO instructions until the result is ready.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears the MD sequencer
- IR_D  in  32  instruction in D
- IR_E  in  32  instruction in E
- A3_E  in  5  destination register of E instruction (0 if no write)
- A3_M  in  5  destination register of M instruction (0 if no write)
- Res_E  in  2  result source of E instruction: 00 none, 01 ALU, 10 DM, 11 PC
- Res_M  in  2  result source of M instruction, same encoding
- Stall  out  1  freezes PC and IF/ID and clears ID/EX this cycle
- MD_start  out  1  mult/multu/div/divu is executing in E this cycle
- MD_op  out  2  00 mult, 01 multu, 10 div, 11 divu (valid with MD_start)
- MD_busy  out  1  HI/LO result still in progress

## Operation
- Source fields: rs_D = IR_D[25:21], rt_D = IR_D[20:16].
- Tuse (cycles until D needs the value):
  - 0: rs of beq/bne/jr; rt of beq/bne.
  - 1: rs of addu/subu/ori/lui/lw/sw/mult/multu/div/divu/mthi/mtlo; rt of addu/subu/sll/mult/multu/div/divu.
  - 2: rt of sw.
  - Any other field or instruction: no use, never stalls.
- Tnew in E: Res_E=ALU → 1, DM → 2, PC → 0, none → no hazard.
- Tnew in M: Res_M=DM → 1, others → 0.
- Data stall condition, per used field f ∈ {rs_D, rt_D}: f≠0 and either of
  - f==A3_E and Tuse(f) < Tnew_E
  - f==A3_M and Tuse(f) < Tnew_M
- Cases not stalled here are resolved by the forwarding muxes. Register $31 written by jal is Tnew 0 and never stalls.
- MD stall condition: IR_D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo and (MD_start or MD_busy).
- Stall = data stall OR MD stall.
- MD sequencer (only sequential state): 4-bit down-counter cnt, MD_busy = (cnt≠0).
  - On a rising edge with MD_start=1: cnt loads MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
  - Otherwise, if cnt≠0, cnt decrements by 1.
  - MD_start cannot coincide with busy, because the MD stall prevents issue. If it does, the load wins.
- MD_start and MD_op are decoded combinationally from IR_E: opcode 0, funct 0x18/0x19/0x1A/0x1B.
- Because Stall clears E, an instruction sits in E for exactly one cycle, so each MD instruction starts the sequencer exactly once.
- Decoding:
  - R-type (opcode 0) funct codes: addu 0x21, subu 0x23, sll 0x00, jr 0x08, mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13.
  - I-type opcodes: beq 0x04, bne 0x05, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B.
  - j 0x02 and jal 0x03 use no registers.

## Timing
- Stall, MD_start and MD_op are purely combinational on the current inputs, valid in the same cycle.
- MD_busy is registered and rises on the edge after MD_start.
  - It stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - A dependent mfhi/mflo in D is stalled for N+1 cycles: the start cycle plus N busy cycles.
- Reset (reset=0) immediately forces cnt=0 and MD_busy=0, asynchronously, including mid-operation. Stall and MD_start still follow their inputs during reset.
- Reset release takes effect on the first rising edge with reset=1.
- Boundary rules:
  - cnt never wraps below 0.
  - An address of 0 never causes a data stall, regardless of Res.
  - Simultaneous data and MD stall conditions give a single Stall=1.

## Test plan
- lw $1 in E (A3_E=1, Res_E=DM), addu $3,$1,$2 in D → Stall=1. Next cycle, with lw in M (Res_M=DM) and a bubble in E → Stall=0 (Tuse 1 ≥ Tnew 1).
- beq $2,$0 in D, addu writing $2 in E (Res_E=ALU) → Stall=1. Same beq with addu in M (Res_M=ALU) → Stall=0.
- jal in E (A3_E=31, Res_E=PC), jr $31 in D → Stall=0. sw $5 in D with lw $5 in E as rt → Stall=0 (Tuse 2 ≥ Tnew 2).
- mult in E, then mflo held in D → MD_start=1 and MD_op=00 in cycle 0. MD_busy=1 in cycles 1–5, 0 in cycle 6. Stall=1 in cycles 0–5, 0 in cycle 6.
- div in E, then reset pulled low for one cycle at busy cycle 4 → MD_busy=0 immediately. After release, mflo in D → Stall=0.
- A3_E=0, Res_E=DM, addu $3,$0,$0 in D → Stall=0.

Source files
------------

// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the five-stage MIPS core: decides D-stage stalls that forwarding
// cannot cover and sequences the multiply/divide unit's busy window.
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  Res_E,
    input  logic [1:0]  Res_M,
    output logic        Stall,
    output logic        MD_start,
    output logic [1:0]  MD_op,
    output logic        MD_busy
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    logic [5:0] op_d, fn_d, op_e, fn_e;
    logic [4:0] rs_d, rt_d;
    logic       r_d;
    logic       is_addu, is_subu, is_sll, is_jr, is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic       is_mdarith, is_beq, is_bne, is_ori, is_lui, is_lw, is_sw;
    logic       rs_use, rt_use;
    logic [1:0] rs_tuse, rt_tuse;
    logic       e_valid;
    logic [1:0] tnew_e, tnew_m;
    logic       data_stall, md_stall, hilo_d;
    logic [3:0] cnt_q, cnt_d;

    // A field stalls only if its producer is too late for the consumer; everything else forwards.
    function automatic logic field_hazard(
        input logic [4:0] f, input logic use_f, input logic [1:0] tuse,
        input logic [4:0] a3e, input logic ev, input logic [1:0] tne,
        input logic [4:0] a3m, input logic [1:0] tnm
    );
        return use_f && (f != 5'd0) &&
               (((f == a3e) && ev && (tuse < tne)) || ((f == a3m) && (tuse < tnm)));
    endfunction

    always_comb begin
        op_d = IR_D[31:26];
        fn_d = IR_D[5:0];
        rs_d = IR_D[25:21];
        rt_d = IR_D[20:16];
        op_e = IR_E[31:26];
        fn_e = IR_E[5:0];
        r_d  = (op_d == 6'h00);

        is_addu    = r_d && (fn_d == 6'h21);
        is_subu    = r_d && (fn_d == 6'h23);
        is_sll     = r_d && (fn_d == 6'h00);
        is_jr      = r_d && (fn_d == 6'h08);
        is_mfhi    = r_d && (fn_d == 6'h10);
        is_mthi    = r_d && (fn_d == 6'h11);
        is_mflo    = r_d && (fn_d == 6'h12);
        is_mtlo    = r_d && (fn_d == 6'h13);
        is_mdarith = r_d && (fn_d[5:2] == 4'b0110);
        is_beq     = (op_d == 6'h04);
        is_bne     = (op_d == 6'h05);
        is_ori     = (op_d == 6'h0D);
        is_lui     = (op_d == 6'h0F);
        is_lw      = (op_d == 6'h23);
        is_sw      = (op_d == 6'h2B);

        rs_use  = is_beq || is_bne || is_jr || is_addu || is_subu || is_ori || is_lui ||
                  is_lw || is_sw || is_mdarith || is_mthi || is_mtlo;
        rs_tuse = (is_beq || is_bne || is_jr) ? 2'd0 : 2'd1;
        rt_use  = is_beq || is_bne || is_addu || is_subu || is_sll || is_mdarith || is_sw;
        rt_tuse = (is_beq || is_bne) ? 2'd0 : (is_sw ? 2'd2 : 2'd1);

        e_valid = (Res_E != 2'b00);
        tnew_e  = 2'd0;
        case (Res_E)
            2'b01:   tnew_e = 2'd1;
            2'b10:   tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
        tnew_m = (Res_M == 2'b10) ? 2'd1 : 2'd0;

        data_stall = field_hazard(rs_d, rs_use, rs_tuse, A3_E, e_valid, tnew_e, A3_M, tnew_m) ||
                     field_hazard(rt_d, rt_use, rt_tuse, A3_E, e_valid, tnew_e, A3_M, tnew_m);

        MD_start = (op_e == 6'h00) && (fn_e[5:2] == 4'b0110);
        MD_op    = fn_e[1:0];
        MD_busy  = (cnt_q != 4'd0);

        hilo_d   = is_mdarith || is_mfhi || is_mflo || is_mthi || is_mtlo;
        md_stall = hilo_d && (MD_start || MD_busy);
        Stall    = data_stall || md_stall;
    end

    // A new start reloads even if a previous operation is still counting down.
    always_comb begin
        cnt_d = cnt_q;
        if (MD_start) begin
            cnt_d = MD_op[1] ? DIV_LD : MULT_LD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed hazard scenarios followed by random instruction pairs,
// all checked against a mnemonic-level model of the hazard and busy rules.
module tb_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] IR_D, IR_E;
    logic [4:0]  A3_E, A3_M;
    logic [1:0]  Res_E, Res_M;
    logic        Stall, MD_start, MD_busy;
    logic [1:0]  MD_op;

    int checks = 0;
    int errors = 0;
    int busy_left = 0;

    typedef enum int {
        M_ADDU, M_SUBU, M_SLL, M_JR, M_MFHI, M_MTHI, M_MFLO, M_MTLO,
        M_MULT, M_MULTU, M_DIV, M_DIVU, M_BEQ, M_BNE, M_ORI, M_LUI,
        M_LW, M_SW, M_J, M_JAL, M_ANDI, M_SLT, M_NUM
    } mn_t;

    stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E),
        .A3_E(A3_E), .A3_M(A3_M), .Res_E(Res_E), .Res_M(Res_M),
        .Stall(Stall), .MD_start(MD_start), .MD_op(MD_op), .MD_busy(MD_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd3, fn};
    endfunction

    function automatic logic [31:0] enc(mn_t m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        case (m)
            M_ADDU:  return rtype(rs, rt, rd, 6'h21);
            M_SUBU:  return rtype(rs, rt, rd, 6'h23);
            M_SLL:   return rtype(rs, rt, rd, 6'h00);
            M_JR:    return rtype(rs, rt, rd, 6'h08);
            M_MFHI:  return rtype(rs, rt, rd, 6'h10);
            M_MTHI:  return rtype(rs, rt, rd, 6'h11);
            M_MFLO:  return rtype(rs, rt, rd, 6'h12);
            M_MTLO:  return rtype(rs, rt, rd, 6'h13);
            M_MULT:  return rtype(rs, rt, rd, 6'h18);
            M_MULTU: return rtype(rs, rt, rd, 6'h19);
            M_DIV:   return rtype(rs, rt, rd, 6'h1A);
            M_DIVU:  return rtype(rs, rt, rd, 6'h1B);
            M_SLT:   return rtype(rs, rt, rd, 6'h2A);
            M_BEQ:   return {6'h04, rs, rt, 16'h0010};
            M_BNE:   return {6'h05, rs, rt, 16'h0010};
            M_ORI:   return {6'h0D, rs, rt, 16'h00a5};
            M_LUI:   return {6'h0F, rs, rt, 16'h1234};
            M_LW:    return {6'h23, rs, rt, 16'h0004};
            M_SW:    return {6'h2B, rs, rt, 16'h0008};
            M_J:     return {6'h02, rs, rt, 16'h0040};
            M_JAL:   return {6'h03, rs, rt, 16'h0040};
            default: return {6'h0C, rs, rt, 16'h00ff};
        endcase
    endfunction

    // Cycles until D needs the register; -1 means the field is not read.
    function automatic int tuse_rs(mn_t m);
        case (m)
            M_BEQ, M_BNE, M_JR: return 0;
            M_ADDU, M_SUBU, M_ORI, M_LUI, M_LW, M_SW,
            M_MULT, M_MULTU, M_DIV, M_DIVU, M_MTHI, M_MTLO: return 1;
            default: return -1;
        endcase
    endfunction

    function automatic int tuse_rt(mn_t m);
        case (m)
            M_BEQ, M_BNE: return 0;
            M_ADDU, M_SUBU, M_SLL, M_MULT, M_MULTU, M_DIV, M_DIVU: return 1;
            M_SW: return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int tnew_e_of(logic [1:0] r);
        case (r)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 0;
            default: return -1;
        endcase
    endfunction

    function automatic bit must_wait(int f, int tu, int a3e, int tne, int a3m, int tnm);
        if (tu < 0 || f == 0) return 1'b0;
        return (f == a3e && tne >= 0 && tu < tne) || (f == a3m && tu < tnm);
    endfunction

    function automatic bit is_mdarith(mn_t m);
        return m == M_MULT || m == M_MULTU || m == M_DIV || m == M_DIVU;
    endfunction

    function automatic bit is_hilo(mn_t m);
        return is_mdarith(m) || m == M_MFHI || m == M_MFLO || m == M_MTHI || m == M_MTLO;
    endfunction

    task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive at negedge, check, then advance the busy model at posedge.
    // want_stall / want_busy of -1 skip the extra hand-computed check.
    task automatic step(string tag, mn_t md, logic [4:0] rs, logic [4:0] rt, mn_t me,
                        logic [4:0] a3e, logic [4:0] a3m, logic [1:0] rese, logic [1:0] resm,
                        logic rst_v, int want_stall, int want_busy);
        bit   exp_start, exp_stall, exp_busy, dstall;
        int   exp_op;
        @(negedge clk);
        IR_D  = enc(md, rs, rt, 5'd7);
        IR_E  = enc(me, 5'd9, 5'd10, a3e);
        A3_E  = a3e;
        A3_M  = a3m;
        Res_E = rese;
        Res_M = resm;
        reset = rst_v;
        if (!rst_v) busy_left = 0;
        #1;
        exp_start = is_mdarith(me);
        exp_op    = (me == M_MULT) ? 0 : (me == M_MULTU) ? 1 : (me == M_DIV) ? 2 : 3;
        exp_busy  = busy_left > 0;
        dstall = must_wait(int'(rs), tuse_rs(md), int'(a3e), tnew_e_of(rese), int'(a3m),
                           (resm == 2'b10) ? 1 : 0) ||
                 must_wait(int'(rt), tuse_rt(md), int'(a3e), tnew_e_of(rese), int'(a3m),
                           (resm == 2'b10) ? 1 : 0);
        exp_stall = dstall || (is_hilo(md) && (exp_start || exp_busy));
        check({tag, ".stall"}, {3'd0, Stall}, {3'd0, exp_stall});
        check({tag, ".start"}, {3'd0, MD_start}, {3'd0, exp_start});
        check({tag, ".busy"}, {3'd0, MD_busy}, {3'd0, exp_busy});
        if (exp_start) check({tag, ".op"}, {2'd0, MD_op}, 4'(exp_op));
        if (want_stall >= 0) check({tag, ".tp_stall"}, {3'd0, Stall}, 4'(want_stall));
        if (want_busy >= 0) check({tag, ".tp_busy"}, {3'd0, MD_busy}, 4'(want_busy));
        @(posedge clk);
        if (reset) begin
            if (exp_start) busy_left = (exp_op >= 2) ? DIV_N : MULT_N;
            else if (busy_left > 0) busy_left--;
        end
    endtask

    initial begin
        reset = 1'b0;
        IR_D = '0; IR_E = '0; A3_E = '0; A3_M = '0; Res_E = '0; Res_M = '0;

        // Stall still follows inputs while reset is held.
        step("rst", M_ADDU, 5'd1, 5'd2, M_LW, 5'd1, 5'd0, 2'b10, 2'b00, 1'b0, 1, 0);
        step("rst2", M_SLL, 5'd0, 5'd0, M_SLL, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 0, 0);

        step("lw_e", M_ADDU, 5'd1, 5'd2, M_LW, 5'd1, 5'd0, 2'b10, 2'b00, 1'b1, 1, -1);
        step("lw_m", M_ADDU, 5'd1, 5'd2, M_SLL, 5'd0, 5'd1, 2'b00, 2'b10, 1'b1, 0, -1);
        step("beq_e", M_BEQ, 5'd2, 5'd0, M_ADDU, 5'd2, 5'd0, 2'b01, 2'b00, 1'b1, 1, -1);
        step("beq_m", M_BEQ, 5'd2, 5'd0, M_SLL, 5'd0, 5'd2, 2'b00, 2'b01, 1'b1, 0, -1);
        step("jal_jr", M_JR, 5'd31, 5'd0, M_JAL, 5'd31, 5'd0, 2'b11, 2'b00, 1'b1, 0, -1);
        step("sw_rt", M_SW, 5'd4, 5'd5, M_LW, 5'd5, 5'd0, 2'b10, 2'b00, 1'b1, 0, -1);
        step("zero", M_ADDU, 5'd0, 5'd0, M_LW, 5'd0, 5'd0, 2'b10, 2'b00, 1'b1, 0, -1);
        step("beq_lw_m", M_BEQ, 5'd3, 5'd0, M_SLL, 5'd0, 5'd3, 2'b00, 2'b10, 1'b1, 1, -1);

        step("mult_c0", M_MFLO, 5'd0, 5'd0, M_MULT, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 1, 0);
        for (int c = 1; c <= MULT_N; c++)
            step("mult_busy", M_MFLO, 5'd0, 5'd0, M_SLL, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 1, 1);
        step("mult_done", M_MFLO, 5'd0, 5'd0, M_SLL, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 0, 0);

        step("div_c0", M_SLL, 5'd0, 5'd0, M_DIV, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 0, 0);
        for (int c = 1; c <= 3; c++)
            step("div_busy", M_SLL, 5'd0, 5'd0, M_SLL, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 0, 1);
        step("div_rst", M_SLL, 5'd0, 5'd0, M_SLL, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 0, 0);
        step("div_after", M_MFLO, 5'd0, 5'd0, M_SLL, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 mn_t'($urandom_range(0, int'(M_NUM) - 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 mn_t'($urandom_range(0, int'(M_NUM) - 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 49) != 0), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
